// File: rtl/sdram_rom_arbiter.sv
// Shares one SDRAM read port among the tile, sprite, CPU and theme ROM clients.
// Define ARB_STARVE_GUARD_EN to build a starvation guard that eventually promotes theme.
module sdram_rom_arbiter (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        i_tiles_req,
  input  logic [17:0] i_tiles_addr,
  input  logic        i_spr_req,
  input  logic [18:0] i_spr_addr,
  input  logic        i_theme_req,
  input  logic [17:0] i_theme_addr,
  input  logic        i_m68k_req,
  input  logic [17:0] i_m68k_addr,
  output logic        o_sd_req,
  output logic [24:0] o_sd_addr,
  input  logic        i_sd_ack,
  input  logic [31:0] i_sd_dout,
  output logic [31:0] o_tiles_dout,
  output logic [31:0] o_spr_dout,
  output logic [31:0] o_theme_dout,
  output logic [15:0] o_m68k_dout,
  output logic        o_m68k_ready
);

  localparam logic [1:0] SrcTiles = 2'd0;
  localparam logic [1:0] SrcSpr   = 2'd1;
  localparam logic [1:0] SrcM68k  = 2'd2;
  localparam logic [1:0] SrcTheme = 2'd3;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e      r_state, w_state_d;
  logic [3:0]  r_pend, w_pend_d;
  logic [17:0] r_tiles_addr, r_theme_addr, r_m68k_addr;
  logic [18:0] r_spr_addr;
  logic [1:0]  r_grant, w_pick;
  logic [24:0] w_pick_addr;
  logic        w_grant_en, w_ack;
  logic        r_sd_req;
  logic [24:0] r_sd_addr;
  logic [31:0] r_tiles_dout, r_spr_dout, r_theme_dout;
  logic [15:0] r_m68k_dout;
  logic        r_m68k_ready;

`ifdef ARB_STARVE_GUARD_EN
  logic [5:0] r_starve;
  logic       w_starve_max;
  assign w_starve_max = (r_starve == 6'd63);
`endif

  always_comb begin
    w_pick = SrcTheme;
    if (r_pend[SrcTiles]) begin
      w_pick = SrcTiles;
    end else if (r_pend[SrcSpr]) begin
      w_pick = SrcSpr;
    end else if (r_pend[SrcM68k]) begin
      w_pick = SrcM68k;
    end
`ifdef ARB_STARVE_GUARD_EN
    if (w_starve_max && r_pend[SrcTheme]) begin
      w_pick = SrcTheme;
    end
`endif
  end

  // Word addresses become byte addresses inside each ROM's SDRAM window.
  always_comb begin
    w_pick_addr = 25'h0;
    unique case (w_pick)
      SrcTiles: w_pick_addr = 25'h0A00000 + {5'b0, r_tiles_addr, 2'b00};
      SrcSpr:   w_pick_addr = 25'h0C00000 + {4'b0, r_spr_addr, 2'b00};
      SrcM68k:  w_pick_addr = {6'b0, r_m68k_addr, 1'b0};
      SrcTheme: w_pick_addr = 25'h0E00000 + {5'b0, r_theme_addr, 2'b00};
      default:  w_pick_addr = 25'h0;
    endcase
  end

  always_comb begin
    w_state_d  = r_state;
    w_grant_en = 1'b0;
    w_ack      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (|r_pend) begin
          w_state_d  = StIssue;
          w_grant_en = 1'b1;
        end
      end
      StIssue: w_state_d = StWait;
      StWait: begin
        if (i_sd_ack) begin
          w_state_d = StIdle;
          w_ack     = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // A fresh request on the ack cycle outranks the clear, so it is not lost.
  always_comb begin
    w_pend_d = r_pend;
    if (w_ack) w_pend_d[r_grant] = 1'b0;
    if (i_tiles_req) w_pend_d[SrcTiles] = 1'b1;
    if (i_spr_req)   w_pend_d[SrcSpr]   = 1'b1;
    if (i_m68k_req)  w_pend_d[SrcM68k]  = 1'b1;
    if (i_theme_req) w_pend_d[SrcTheme] = 1'b1;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_pend       <= 4'b0;
      r_tiles_addr <= 18'h0;
      r_spr_addr   <= 19'h0;
      r_theme_addr <= 18'h0;
      r_m68k_addr  <= 18'h0;
      r_grant      <= SrcTiles;
      r_sd_req     <= 1'b0;
      r_sd_addr    <= 25'h0;
    end else begin
      r_state  <= w_state_d;
      r_pend   <= w_pend_d;
      r_sd_req <= w_grant_en;
      if (i_tiles_req) r_tiles_addr <= i_tiles_addr;
      if (i_spr_req)   r_spr_addr   <= i_spr_addr;
      if (i_theme_req) r_theme_addr <= i_theme_addr;
      if (i_m68k_req)  r_m68k_addr  <= i_m68k_addr;
      if (w_grant_en) begin
        r_grant   <= w_pick;
        r_sd_addr <= w_pick_addr;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_tiles_dout <= 32'h0;
      r_spr_dout   <= 32'h0;
      r_theme_dout <= 32'h0;
      r_m68k_dout  <= 16'h0;
      r_m68k_ready <= 1'b1;
    end else begin
      if (w_ack) begin
        unique case (r_grant)
          SrcTiles: r_tiles_dout <= i_sd_dout;
          SrcSpr:   r_spr_dout   <= i_sd_dout;
          SrcM68k:  r_m68k_dout  <= i_sd_dout[15:0];
          SrcTheme: r_theme_dout <= i_sd_dout;
          default:  r_tiles_dout <= r_tiles_dout;
        endcase
      end
      if (i_m68k_req) begin
        r_m68k_ready <= 1'b0;
      end else if (w_ack && (r_grant == SrcM68k)) begin
        r_m68k_ready <= 1'b1;
      end
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_starve <= 6'd0;
    end else if (w_grant_en) begin
      if (w_pick == SrcTheme) begin
        r_starve <= 6'd0;
      end else if (r_pend[SrcTheme] && !w_starve_max) begin
        r_starve <= r_starve + 6'd1;
      end
    end
  end
`endif

  assign o_sd_req     = r_sd_req;
  assign o_sd_addr    = r_sd_addr;
  assign o_tiles_dout = r_tiles_dout;
  assign o_spr_dout   = r_spr_dout;
  assign o_theme_dout = r_theme_dout;
  assign o_m68k_dout  = r_m68k_dout;
  assign o_m68k_ready = r_m68k_ready;

endmodule

// File: tb/tb_sdram_rom_arbiter.sv
// Self-checking bench for sdram_rom_arbiter: vector table, sd_addr scoreboard, corner sequences.
module tb_sdram_rom_arbiter;

  localparam int SrcTiles = 0;
  localparam int SrcSpr   = 1;
  localparam int SrcM68k  = 2;
  localparam int SrcTheme = 3;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b0;
  logic        i_tiles_req = 1'b0, i_spr_req = 1'b0, i_theme_req = 1'b0, i_m68k_req = 1'b0;
  logic [17:0] i_tiles_addr = '0, i_theme_addr = '0, i_m68k_addr = '0;
  logic [18:0] i_spr_addr = '0;
  logic        i_sd_ack = 1'b0;
  logic [31:0] i_sd_dout = '0;
  logic        o_sd_req;
  logic [24:0] o_sd_addr;
  logic [31:0] o_tiles_dout, o_spr_dout, o_theme_dout;
  logic [15:0] o_m68k_dout;
  logic        o_m68k_ready;

  always #5 clk_sys = ~clk_sys;

  sdram_rom_arbiter dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .i_tiles_req  (i_tiles_req),
    .i_tiles_addr (i_tiles_addr),
    .i_spr_req    (i_spr_req),
    .i_spr_addr   (i_spr_addr),
    .i_theme_req  (i_theme_req),
    .i_theme_addr (i_theme_addr),
    .i_m68k_req   (i_m68k_req),
    .i_m68k_addr  (i_m68k_addr),
    .o_sd_req     (o_sd_req),
    .o_sd_addr    (o_sd_addr),
    .i_sd_ack     (i_sd_ack),
    .i_sd_dout    (i_sd_dout),
    .o_tiles_dout (o_tiles_dout),
    .o_spr_dout   (o_spr_dout),
    .o_theme_dout (o_theme_dout),
    .o_m68k_dout  (o_m68k_dout),
    .o_m68k_ready (o_m68k_ready)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_sdreq = 0;
  logic [24:0] exp_q[$];
  logic [31:0] m_dout[4];

  typedef struct {
    int          src;
    logic [18:0] addr;
    logic [31:0] data;
    logic [24:0] exp_addr;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Every sd_req cycle consumes one expected byte address.
  always @(negedge clk_sys) begin
    if (o_sd_req) begin
      n_sdreq++;
      if (exp_q.size() == 0) begin
        check("sd_req_unexpected", {7'b0, o_sd_addr}, 32'hFFFF_FFFF);
      end else begin
        check("sd_addr", {7'b0, o_sd_addr}, {7'b0, exp_q.pop_front()});
      end
    end
  end

  function automatic logic [31:0] dut_dout(input int src);
    case (src)
      SrcTiles: return o_tiles_dout;
      SrcSpr:   return o_spr_dout;
      SrcM68k:  return {16'h0, o_m68k_dout};
      default:  return o_theme_dout;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic set_req(input int src, input logic [18:0] addr);
    case (src)
      SrcTiles: begin i_tiles_req = 1'b1; i_tiles_addr = addr[17:0]; end
      SrcSpr:   begin i_spr_req   = 1'b1; i_spr_addr   = addr;       end
      SrcM68k:  begin i_m68k_req  = 1'b1; i_m68k_addr  = addr[17:0]; end
      default:  begin i_theme_req = 1'b1; i_theme_addr = addr[17:0]; end
    endcase
  endtask

  task automatic clr_reqs;
    i_tiles_req = 1'b0;
    i_spr_req   = 1'b0;
    i_m68k_req  = 1'b0;
    i_theme_req = 1'b0;
  endtask

  task automatic wait_sdreq(output int waited);
    int start;
    start  = n_sdreq;
    waited = 0;
    while (n_sdreq == start && waited < 50) begin
      tick();
      waited++;
    end
    if (n_sdreq == start) check("sd_req_timeout", n_sdreq, start + 1);
  endtask

  task automatic do_ack(input logic [31:0] data);
    tick();
    tick();
    i_sd_ack  = 1'b1;
    i_sd_dout = data;
    tick();
    i_sd_ack  = 1'b0;
    i_sd_dout = '0;
  endtask

  task automatic check_douts(input string tag);
    for (int s = 0; s < 4; s++) check($sformatf("%s_dout%0d", tag, s), dut_dout(s), m_dout[s]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int base;
    vecs[0] = '{SrcTiles, 19'h00010, 32'hDEADBEEF, 25'h0A00040, 32'hDEADBEEF};
    vecs[1] = '{SrcSpr,   19'h00005, 32'h12345678, 25'h0C00014, 32'h12345678};
    vecs[2] = '{SrcTheme, 19'h3FFFF, 32'hCAFEF00D, 25'h0EFFFFC, 32'hCAFEF00D};
    vecs[3] = '{SrcM68k,  19'h00003, 32'hA5A51234, 25'h0000006, 32'h00001234};
    vecs[4] = '{SrcM68k,  19'h3FFFF, 32'h0000BEEF, 25'h007FFFE, 32'h0000BEEF};
    vecs[5] = '{SrcSpr,   19'h7FFFF, 32'h0F0F0F0F, 25'h0DFFFFC, 32'h0F0F0F0F};
    vecs[6] = '{SrcTiles, 19'h3FFFF, 32'h76543210, 25'h0AFFFFC, 32'h76543210};
    for (int s = 0; s < 4; s++) m_dout[s] = '0;

    #2;
    reset = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    reset = 1'b0;
    check("rst_sd_req", {31'b0, o_sd_req}, 32'd0);
    check("rst_sd_addr", {7'b0, o_sd_addr}, 32'd0);
    check("rst_ready", {31'b0, o_m68k_ready}, 32'd1);
    check_douts("rst");
    tick();

    // Single transactions on an idle arbiter.
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(vecs[i].exp_addr);
      set_req(vecs[i].src, vecs[i].addr);
      tick();
      clr_reqs();
      if (vecs[i].src == SrcM68k) check("vec_ready_low", {31'b0, o_m68k_ready}, 32'd0);
      wait_sdreq(w);
      check("vec_latency", w, 2);
      do_ack(vecs[i].data);
      m_dout[vecs[i].src] = vecs[i].exp_dout;
      check_douts("vec");
      check("vec_ready_high", {31'b0, o_m68k_ready}, 32'd1);
      tick();
    end

    // Ack while idle must be ignored.
    i_sd_ack  = 1'b1;
    i_sd_dout = 32'hFFFF_FFFF;
    tick();
    tick();
    i_sd_ack  = 1'b0;
    i_sd_dout = '0;
    check_douts("stray_ack");

    // Simultaneous spr/m68k/theme: served spr, m68k, theme.
    exp_q.push_back(25'h0C00024);
    exp_q.push_back(25'h0000006);
    exp_q.push_back(25'h0E00044);
    set_req(SrcSpr, 19'h00009);
    set_req(SrcM68k, 19'h00003);
    set_req(SrcTheme, 19'h00011);
    tick();
    clr_reqs();
    check("prio_ready_low0", {31'b0, o_m68k_ready}, 32'd0);
    wait_sdreq(w);
    do_ack(32'h1111_0001);
    m_dout[SrcSpr] = 32'h1111_0001;
    check_douts("prio_spr");
    check("prio_ready_low1", {31'b0, o_m68k_ready}, 32'd0);
    wait_sdreq(w);
    check("b2b_gap", w, 2);
    check("prio_ready_low2", {31'b0, o_m68k_ready}, 32'd0);
    do_ack(32'h2222_ABCD);
    m_dout[SrcM68k] = 32'h0000_ABCD;
    check_douts("prio_m68k");
    check("prio_ready_high", {31'b0, o_m68k_ready}, 32'd1);
    wait_sdreq(w);
    do_ack(32'h3333_0003);
    m_dout[SrcTheme] = 32'h3333_0003;
    check_douts("prio_theme");

    // Repeated tiles request while pending: latest address, one access.
    base = n_sdreq;
    exp_q.push_back(25'h0C00004);
    exp_q.push_back(25'h0A00008);
    set_req(SrcSpr, 19'h00001);
    tick();
    clr_reqs();
    wait_sdreq(w);
    set_req(SrcTiles, 19'h00001);
    tick();
    set_req(SrcTiles, 19'h00002);
    tick();
    clr_reqs();
    do_ack(32'h4444_0001);
    m_dout[SrcSpr] = 32'h4444_0001;
    wait_sdreq(w);
    do_ack(32'h4444_0002);
    m_dout[SrcTiles] = 32'h4444_0002;
    check_douts("latest");
    repeat (10) tick();
    check("latest_one_access", n_sdreq, base + 2);

    // New m68k request on its own ack cycle stays pending with the new address.
    exp_q.push_back(25'h0000200);
    exp_q.push_back(25'h0000400);
    set_req(SrcM68k, 19'h00100);
    tick();
    clr_reqs();
    wait_sdreq(w);
    tick();
    tick();
    i_sd_ack  = 1'b1;
    i_sd_dout = 32'h0BAD_5EED;
    set_req(SrcM68k, 19'h00200);
    tick();
    i_sd_ack  = 1'b0;
    clr_reqs();
    m_dout[SrcM68k] = 32'h0000_5EED;
    check_douts("rereq");
    check("rereq_ready_low", {31'b0, o_m68k_ready}, 32'd0);
    wait_sdreq(w);
    do_ack(32'h0000_7777);
    m_dout[SrcM68k] = 32'h0000_7777;
    check_douts("rereq2");
    check("rereq_ready_high", {31'b0, o_m68k_ready}, 32'd1);

    // Reset during WAIT, then a late ack.
    exp_q.push_back(25'h0A00110);
    set_req(SrcM68k, 19'h00044);
    set_req(SrcTiles, 19'h00044);
    tick();
    clr_reqs();
    wait_sdreq(w);
    tick();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    for (int s = 0; s < 4; s++) m_dout[s] = '0;
    check("wrst_sd_req", {31'b0, o_sd_req}, 32'd0);
    check("wrst_sd_addr", {7'b0, o_sd_addr}, 32'd0);
    check("wrst_ready", {31'b0, o_m68k_ready}, 32'd1);
    base = n_sdreq;
    tick();
    i_sd_ack  = 1'b1;
    i_sd_dout = 32'h9999_9999;
    tick();
    i_sd_ack  = 1'b0;
    i_sd_dout = '0;
    repeat (8) tick();
    check_douts("wrst_late_ack");
    check("wrst_ready_after", {31'b0, o_m68k_ready}, 32'd1);
    check("wrst_no_sd_req", n_sdreq, base);
    exp_q.push_back(25'h0000006);
    set_req(SrcM68k, 19'h00003);
    tick();
    clr_reqs();
    wait_sdreq(w);
    check("wrst_recover_latency", w, 2);
    do_ack(32'h0000_4321);
    m_dout[SrcM68k] = 32'h0000_4321;
    check_douts("wrst_recover");

    // Theme pending against a continuous tiles stream.
    for (int i = 0; i < 66; i++) begin
      int src_e;
`ifdef ARB_STARVE_GUARD_EN
      src_e = (i == 63) ? SrcTheme : SrcTiles;
`else
      src_e = SrcTiles;
`endif
      exp_q.push_back((src_e == SrcTheme) ? 25'h0E0001C : 25'h0A00080);
      if (i == 0) begin
        set_req(SrcTheme, 19'h00007);
        set_req(SrcTiles, 19'h00020);
        tick();
        i_theme_req = 1'b0;
      end
      wait_sdreq(w);
      if (i == 65) i_tiles_req = 1'b0;
      do_ack(32'h5000_0000 + i);
      m_dout[src_e] = 32'h5000_0000 + i;
    end
    check_douts("starve");
`ifndef ARB_STARVE_GUARD_EN
    exp_q.push_back(25'h0E0001C);
    wait_sdreq(w);
    do_ack(32'h6000_0001);
    m_dout[SrcTheme] = 32'h6000_0001;
    check_douts("starve_drain");
`endif
    repeat (10) tick();
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
